// File: rtl/sub_share_arb_if.sv
// sub_share_arb_if: requester/response bundle for the shared 8-bit subtractor.
// The master side is the requester logic plus the response consumer.
// The slave side is the arbiter.
interface sub_share_arb_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] a_flat;
  logic [NREQ*DATA_W-1:0] b_flat;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_diff;
  logic                   rsp_borrow;

  modport master (
    output req, a_flat, b_flat, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, rsp_diff, rsp_borrow
  );

  modport slave (
    input  req, a_flat, b_flat, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, rsp_diff, rsp_borrow
  );
endinterface

// File: rtl/sub_share_arb.sv
// sub_share_arb: round-robin arbiter that shares one 8-bit subtractor among
// four requesters. Each transaction is grant/capture -> execute -> response
// hold until the consumer accepts it, so issue spacing is at least 3 cycles.
//
// Build option: define SUB_SHARE_ARB_SAT_EN to clamp the difference to 0x00
// whenever a < b. Without it the difference wraps mod 256. The borrow flag
// reports a < b in both modes; timing and arbitration do not change.
module sub_share_arb #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sub_share_arb_if.slave  bus
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned subtract with the borrow carried out as the extra MSB.
  function automatic logic [DATA_W:0] sub_wide(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    sub_wide = {1'b0, a} - {1'b0, b};
  endfunction

  // Final difference: either wrap-around or clamped at zero on borrow.
  function automatic logic [DATA_W-1:0] sat_diff(input logic [DATA_W:0] wide);
`ifdef SUB_SHARE_ARB_SAT_EN
    sat_diff = wide[DATA_W] ? '0 : wide[DATA_W-1:0];
`else
    sat_diff = wide[DATA_W-1:0];
`endif
  endfunction

  state_t            state;
  logic [ID_W-1:0]   ptr;

  // Stage p0: grant edge, winner operands and id captured
  logic [NREQ-1:0]   gnt_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [ID_W-1:0]   id_p0;

  // Stage p1: response held until accepted
  logic              vld_p1;
  logic [ID_W-1:0]   id_p1;
  logic [DATA_W-1:0] diff_p1;
  logic              borrow_p1;

  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic [DATA_W:0]   wide;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + ID_W'(k);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_a = bus.a_flat[win_id*DATA_W +: DATA_W];
  assign win_b = bus.b_flat[win_id*DATA_W +: DATA_W];
  assign wide  = sub_wide(a_p0, b_p0);

  // Sequencer: arbitrate in IDLE, compute in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(NREQ - 1);
      gnt_p0    <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= '0;
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      diff_p1   <= '0;
      borrow_p1 <= 1'b0;
    end else begin
      gnt_p0 <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            a_p0   <= win_a;
            b_p0   <= win_b;
            id_p0  <= win_id;
            ptr    <= win_id;
            gnt_p0 <= NREQ'(1) << win_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          diff_p1   <= sat_diff(wide);
          borrow_p1 <= wide[DATA_W];
          id_p1     <= id_p0;
          vld_p1    <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_p0;
  assign bus.busy       = (state != IDLE);
  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = id_p1;
  assign bus.rsp_diff   = diff_p1;
  assign bus.rsp_borrow = borrow_p1;

endmodule

// File: tb/tb_sub_share_arb.sv
// tb_sub_share_arb: vector table plus hand-written sequences for sub_share_arb.
// Inputs change 1 time unit after each rising edge. Responses are checked
// against a queue of expected results at the falling edge before the
// accepting rising edge.
module tb_sub_share_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sub_share_arb_if bus_if ();

  sub_share_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] diff;
    logic       borrow;
  } rsp_t;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] gnt;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference for the response difference.
  function automatic logic [7:0] model_diff(input logic [7:0] a, input logic [7:0] b);
`ifdef SUB_SHARE_ARB_SAT_EN
    model_diff = (a < b) ? 8'h00 : 8'(a - b);
`else
    model_diff = 8'(a - b);
`endif
  endfunction

  function automatic rsp_t mk_rsp(input int id, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    r.id     = 2'(id);
    r.diff   = model_diff(a, b);
    r.borrow = (a < b);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    bus_if.a_flat[id*8 +: 8] = a;
    bus_if.b_flat[id*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Response scoreboard: every accepted response must match the queue head.
  always @(negedge clk) begin
    if (rst_n && bus_if.rsp_valid && bus_if.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(bus_if.rsp_id), 32'hFFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_id",     32'(bus_if.rsp_id),     32'(e.id));
        chk("rsp_diff",   32'(bus_if.rsp_diff),   32'(e.diff));
        chk("rsp_borrow", 32'(bus_if.rsp_borrow), 32'(e.borrow));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{id: 0, a: 8'h50, b: 8'h20, gnt: 4'b0001, diff: 8'h30, borrow: 1'b0};
`ifdef SUB_SHARE_ARB_SAT_EN
    vecs[1] = '{id: 2, a: 8'h10, b: 8'h20, gnt: 4'b0100, diff: 8'h00, borrow: 1'b1};
    vecs[3] = '{id: 3, a: 8'h00, b: 8'hFF, gnt: 4'b1000, diff: 8'h00, borrow: 1'b1};
    vecs[5] = '{id: 0, a: 8'h7F, b: 8'h80, gnt: 4'b0001, diff: 8'h00, borrow: 1'b1};
`else
    vecs[1] = '{id: 2, a: 8'h10, b: 8'h20, gnt: 4'b0100, diff: 8'hF0, borrow: 1'b1};
    vecs[3] = '{id: 3, a: 8'h00, b: 8'hFF, gnt: 4'b1000, diff: 8'h01, borrow: 1'b1};
    vecs[5] = '{id: 0, a: 8'h7F, b: 8'h80, gnt: 4'b0001, diff: 8'hFF, borrow: 1'b1};
`endif
    vecs[2] = '{id: 1, a: 8'hFF, b: 8'h00, gnt: 4'b0010, diff: 8'hFF, borrow: 1'b0};
    vecs[4] = '{id: 1, a: 8'h80, b: 8'h80, gnt: 4'b0010, diff: 8'h00, borrow: 1'b0};

    bus_if.req       = '0;
    bus_if.a_flat    = '0;
    bus_if.b_flat    = '0;
    bus_if.rsp_ready = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_gnt",        32'(bus_if.gnt),        32'h0);
    chk("rst_busy",       32'(bus_if.busy),       32'h0);
    chk("rst_rsp_valid",  32'(bus_if.rsp_valid),  32'h0);
    chk("rst_rsp_id",     32'(bus_if.rsp_id),     32'h0);
    chk("rst_rsp_diff",   32'(bus_if.rsp_diff),   32'h0);
    chk("rst_rsp_borrow", 32'(bus_if.rsp_borrow), 32'h0);
    rst_n = 1'b1;
    bus_if.rsp_ready = 1'b1;

    // Single-requester vectors
    for (int i = 0; i < 6; i++) begin
      set_op(vecs[i].id, vecs[i].a, vecs[i].b);
      bus_if.req = 4'(1 << vecs[i].id);
      exp_q.push_back('{id: 2'(vecs[i].id), diff: vecs[i].diff, borrow: vecs[i].borrow});
      step();
      chk("vec_gnt",  32'(bus_if.gnt),  32'(vecs[i].gnt));
      chk("vec_busy", 32'(bus_if.busy), 32'h1);
      bus_if.req = '0;
      step();
      chk("vec_valid",    32'(bus_if.rsp_valid), 32'h1);
      chk("vec_gnt_pulse", 32'(bus_if.gnt),      32'h0);
      step();
      chk("vec_valid_clr", 32'(bus_if.rsp_valid), 32'h0);
      chk("vec_idle",      32'(bus_if.busy),      32'h0);
    end

    // Four simultaneous requests from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(8'h40 + i * 8'h11), 8'(i * 5));
    bus_if.req = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] eg;
      int         gid;
      step();
      gid = (k - 1) / 3;
      eg  = ((k % 3) == 1) ? 4'(1 << gid) : 4'b0000;
      chk("rr4_gnt", 32'(bus_if.gnt), 32'(eg));
      if (eg != 4'b0000) begin
        exp_q.push_back(mk_rsp(gid, 8'(8'h40 + gid * 8'h11), 8'(gid * 5)));
        bus_if.req[gid] = 1'b0;
      end
    end

    // Backpressure with requester 2 pending
    bus_if.rsp_ready = 1'b0;
    set_op(0, 8'h90, 8'h35);
    set_op(2, 8'h05, 8'h06);
    bus_if.req = 4'b0001;
    exp_q.push_back(mk_rsp(0, 8'h90, 8'h35));
    step();
    chk("bp_gnt0", 32'(bus_if.gnt), 32'b0001);
    bus_if.req = 4'b0100;
    set_op(0, 8'h00, 8'hFF);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",  32'(bus_if.rsp_valid),  32'h1);
      chk("bp_busy",   32'(bus_if.busy),       32'h1);
      chk("bp_gnt",    32'(bus_if.gnt),        32'h0);
      chk("bp_id",     32'(bus_if.rsp_id),     32'h0);
      chk("bp_diff",   32'(bus_if.rsp_diff),   32'h5B);
      chk("bp_borrow", 32'(bus_if.rsp_borrow), 32'h0);
      step();
    end
    chk("bp_valid_hold", 32'(bus_if.rsp_valid), 32'h1);
    bus_if.rsp_ready = 1'b1;
    step();
    chk("bp_valid_clr", 32'(bus_if.rsp_valid), 32'h0);
    chk("bp_no_gnt",    32'(bus_if.gnt),       32'h0);
    step();
    chk("bp_gnt2", 32'(bus_if.gnt), 32'b0100);
    exp_q.push_back(mk_rsp(2, 8'h05, 8'h06));
    bus_if.req = '0;
    step();
    step();

    // Fairness between requesters 0 and 2
    do_reset();
    set_op(0, 8'h33, 8'h11);
    set_op(2, 8'h44, 8'h55);
    bus_if.req = 4'b0101;
    for (int g = 0; g < 6; g++) begin
      step();
      if ((g % 2) == 0) begin
        chk("fair_gnt", 32'(bus_if.gnt), 32'b0001);
        exp_q.push_back(mk_rsp(0, 8'h33, 8'h11));
      end else begin
        chk("fair_gnt", 32'(bus_if.gnt), 32'b0100);
        exp_q.push_back(mk_rsp(2, 8'h44, 8'h55));
      end
      step();
      step();
    end
    bus_if.req = '0;
    step();
    chk("fair_quiet", 32'(bus_if.gnt), 32'h0);

    // Reset while a response is held
    bus_if.rsp_ready = 1'b0;
    set_op(1, 8'h21, 8'h01);
    bus_if.req = 4'b0010;
    step();
    chk("mr_gnt", 32'(bus_if.gnt), 32'b0010);
    bus_if.req = '0;
    step();
    chk("mr_valid", 32'(bus_if.rsp_valid), 32'h1);
    chk("mr_id",    32'(bus_if.rsp_id),    32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", 32'(bus_if.rsp_valid), 32'h0);
    chk("mr_rst_busy",  32'(bus_if.busy),      32'h0);
    chk("mr_rst_gnt",   32'(bus_if.gnt),       32'h0);
    chk("mr_rst_id",    32'(bus_if.rsp_id),    32'h0);
    chk("mr_rst_diff",  32'(bus_if.rsp_diff),  32'h0);
    set_op(1, 8'h0A, 8'h03);
    set_op(3, 8'h03, 8'h0A);
    bus_if.req = 4'b1010;
    bus_if.rsp_ready = 1'b1;
    step();
    chk("mr_hold_gnt", 32'(bus_if.gnt), 32'h0);
    rst_n = 1'b1;
    exp_q.push_back(mk_rsp(1, 8'h0A, 8'h03));
    step();
    chk("mr_first_gnt", 32'(bus_if.gnt), 32'b0010);
    bus_if.req = 4'b1000;
    step();
    step();
    step();
    chk("mr_second_gnt", 32'(bus_if.gnt), 32'b1000);
    exp_q.push_back(mk_rsp(3, 8'h03, 8'h0A));
    bus_if.req = '0;
    step();
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
